// File: rtl/mips16_sram_core.sv
`default_nettype none
// ============================================================================
// Module      : mips16_sram_core
// Description : Multicycle 16-bit MIPS-style core that shares one external
//               asynchronous 256K x 16 SRAM port for instruction fetch and
//               data load/store (von Neumann).
// Revision    : 1.0 - initial release
// ============================================================================
module mips16_sram_core #(
    parameter int              ADDR_W   = 18,
    parameter int              DATA_W   = 16,
    parameter logic [DATA_W-1:0] RESET_PC = 16'h0000
) (
    input  logic              clock,
    input  logic              reset,
    output logic [ADDR_W-1:0] addr,
    inout  wire  [DATA_W-1:0] data,
    output logic              wre,
    output logic              oute,
    output logic              hb_mask,
    output logic              lb_mask,
    output logic              chip_en
);

    localparam logic [2:0] c_FETCH  = 3'd0;
    localparam logic [2:0] c_DECODE = 3'd1;
    localparam logic [2:0] c_EXEC   = 3'd2;
    localparam logic [2:0] c_MEMRD  = 3'd3;
    localparam logic [2:0] c_MEMWR  = 3'd4;
    localparam logic [2:0] c_WB     = 3'd5;
    localparam logic [2:0] c_HALT   = 3'd6;

    localparam logic [3:0] c_OP_R    = 4'd0;
    localparam logic [3:0] c_OP_ADDI = 4'd1;
    localparam logic [3:0] c_OP_LW   = 4'd2;
    localparam logic [3:0] c_OP_SW   = 4'd3;
    localparam logic [3:0] c_OP_BEQ  = 4'd4;
    localparam logic [3:0] c_OP_BNE  = 4'd5;
    localparam logic [3:0] c_OP_J    = 4'd6;
    localparam logic [3:0] c_OP_SB   = 4'd7;
    localparam logic [3:0] c_OP_HALT = 4'd8;

    localparam logic [DATA_W-1:0] c_ONE = {{(DATA_W-1){1'b0}}, 1'b1};

    logic [2:0]        r_state;
    logic [DATA_W-1:0] r_pc;
    logic [DATA_W-1:0] r_ir;
    logic [DATA_W-1:0] r_rf [0:7];
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [DATA_W-1:0] r_res;   // ALU result or effective address
    logic [DATA_W-1:0] r_mdr;

    logic [3:0]        w_op;
    logic [2:0]        w_rs;
    logic [2:0]        w_rt;
    logic [2:0]        w_rd;
    logic [2:0]        w_funct;
    logic [2:0]        w_dest;
    logic [DATA_W-1:0] w_imm;
    logic [DATA_W-1:0] w_alu;
    logic [DATA_W-1:0] w_bus_addr;
    logic              w_drive;

    assign w_op    = r_ir[15:12];
    assign w_rs    = r_ir[11:9];
    assign w_rt    = r_ir[8:6];
    assign w_rd    = r_ir[5:3];
    assign w_funct = r_ir[2:0];
    assign w_imm   = {{(DATA_W-6){r_ir[5]}}, r_ir[5:0]};
    assign w_dest  = (w_op == c_OP_R) ? w_rd : w_rt;

    // ALU: R-type operations by funct, everything else computes rs + sext(imm)
    always_comb begin
        w_alu = r_a + w_imm;
        if (w_op == c_OP_R) begin
            case (w_funct)
                3'd0:    w_alu = r_a + r_b;
                3'd1:    w_alu = r_a - r_b;
                3'd2:    w_alu = r_a & r_b;
                3'd3:    w_alu = r_a | r_b;
                3'd4:    w_alu = r_a ^ r_b;
                3'd5:    w_alu = ($signed(r_a) < $signed(r_b)) ? c_ONE : '0;
                3'd6:    w_alu = {r_a[DATA_W-2:0], 1'b0};
                default: w_alu = {1'b0, r_a[DATA_W-1:1]};
            endcase
        end
    end

    // Sequencer, datapath registers and register file
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= c_FETCH;
            r_pc    <= RESET_PC;
            r_ir    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_mdr   <= '0;
            for (int i = 0; i < 8; i++) begin
                r_rf[i] <= '0;
            end
        end else begin
            case (r_state)
                c_FETCH: begin
                    r_ir    <= data;
                    r_pc    <= r_pc + c_ONE;
                    r_state <= c_DECODE;
                end
                c_DECODE: begin
                    // r0 is never written, so it always reads back as zero
                    r_a     <= r_rf[w_rs];
                    r_b     <= r_rf[w_rt];
                    r_state <= c_EXEC;
                end
                c_EXEC: begin
                    r_res <= w_alu;
                    case (w_op)
                        c_OP_R, c_OP_ADDI: r_state <= c_WB;
                        c_OP_LW:           r_state <= c_MEMRD;
                        c_OP_SW, c_OP_SB:  r_state <= c_MEMWR;
                        c_OP_BEQ: begin
                            if (r_a == r_b) r_pc <= r_pc + w_imm;
                            r_state <= c_FETCH;
                        end
                        c_OP_BNE: begin
                            if (r_a != r_b) r_pc <= r_pc + w_imm;
                            r_state <= c_FETCH;
                        end
                        c_OP_J: begin
                            r_pc    <= {r_pc[DATA_W-1:12], r_ir[11:0]};
                            r_state <= c_FETCH;
                        end
                        c_OP_HALT:         r_state <= c_HALT;
                        default:           r_state <= c_FETCH;
                    endcase
                end
                c_MEMRD: begin
                    r_mdr   <= data;
                    r_state <= c_WB;
                end
                c_MEMWR: begin
                    r_state <= c_FETCH;
                end
                c_WB: begin
                    if (w_dest != 3'd0) begin
                        r_rf[w_dest] <= (w_op == c_OP_LW) ? r_mdr : r_res;
                    end
                    r_state <= c_FETCH;
                end
                c_HALT: begin
                    r_state <= c_HALT;
                end
                default: begin
                    r_state <= c_FETCH;
                end
            endcase
        end
    end

    // SRAM strobes decoded from state; forced idle while reset is asserted
    always_comb begin
        w_bus_addr = '0;
        chip_en    = 1'b0;
        oute       = 1'b0;
        wre        = 1'b0;
        hb_mask    = 1'b0;
        lb_mask    = 1'b0;
        if (reset) begin
            case (r_state)
                c_FETCH: begin
                    w_bus_addr = r_pc;
                    chip_en    = 1'b1;
                    oute       = 1'b1;
                    hb_mask    = 1'b1;
                    lb_mask    = 1'b1;
                end
                c_MEMRD: begin
                    w_bus_addr = r_res;
                    chip_en    = 1'b1;
                    oute       = 1'b1;
                    hb_mask    = 1'b1;
                    lb_mask    = 1'b1;
                end
                c_MEMWR: begin
                    w_bus_addr = r_res;
                    chip_en    = 1'b1;
                    wre        = 1'b1;
                    hb_mask    = (w_op != c_OP_SB);
                    lb_mask    = 1'b1;
                end
                default: begin
                    w_bus_addr = '0;
                end
            endcase
        end
    end

    assign addr    = {{(ADDR_W-DATA_W){1'b0}}, w_bus_addr};
    assign w_drive = reset && (r_state == c_MEMWR);
    assign data    = w_drive ? r_b : {DATA_W{1'bz}};

endmodule
`default_nettype wire

// File: tb/tb_mips16_sram_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_mips16_sram_core
// Description : Self-checking bench for mips16_sram_core. An instruction-level
//               model predicts the SRAM bus activity cycle by cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mips16_sram_core;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [17:0] addr;
    wire  [15:0] data;
    logic        wre, oute, hb_mask, lb_mask, chip_en;

    mips16_sram_core #(.ADDR_W(18), .DATA_W(16), .RESET_PC(16'h0000)) dut (
        .clock   (clock),
        .reset   (reset),
        .addr    (addr),
        .data    (data),
        .wre     (wre),
        .oute    (oute),
        .hb_mask (hb_mask),
        .lb_mask (lb_mask),
        .chip_en (chip_en)
    );

    always #5 clock = ~clock;

    // Asynchronous SRAM: combinational read; writes applied by the main process
    logic [15:0] mem [0:65535];
    logic [15:0] mm  [0:65535];
    assign data = (chip_en && oute && !wre) ? mem[addr[15:0]] : 16'hzzzz;

    typedef struct packed {
        logic        ce, oe, we, hb, lb;
        logic [17:0] addr;
        logic [15:0] wd;
    } bus_t;

    typedef struct {
        int   cyc;
        bus_t b;
    } pin_t;

    bus_t exp_q[$];
    pin_t pins[$];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h required %h", name, act, req);
    endtask

    function automatic bus_t mk(input logic ce, oe, we, hb, lb,
                                input logic [15:0] a, input logic [15:0] wd);
        bus_t b;
        b.ce = ce; b.oe = oe; b.we = we; b.hb = hb; b.lb = lb;
        b.addr = {2'b00, a};
        b.wd = wd;
        return b;
    endfunction

    function automatic bus_t dut_bus();
        return mk(chip_en, oute, wre, hb_mask, lb_mask, addr[15:0], wre ? data : 16'h0000)
               | {5'b0, addr[17:16], 16'h0, 16'h0};
    endfunction

    // Instruction-level model: executes the program and lists the bus cycles
    // each instruction produces (fetch, two internal cycles, then any access)
    task automatic build(input int k);
        logic [15:0] pc, ir, a, b, se, ea, r;
        logic [15:0] rf [0:7];
        logic [3:0]  op;
        logic [2:0]  rs, rt, rd, fn;
        bit          halted;
        bus_t        idle;
        idle = mk(0, 0, 0, 0, 0, 16'h0, 16'h0);
        exp_q.delete();
        mm = mem;
        pc = 16'h0000;
        for (int i = 0; i < 8; i++) rf[i] = 16'h0;
        halted = 0;
        while (exp_q.size() < k) begin
            if (halted) begin
                exp_q.push_back(idle);
                continue;
            end
            exp_q.push_back(mk(1, 1, 0, 1, 1, pc, 16'h0));
            ir = mm[pc];
            pc = pc + 16'd1;
            exp_q.push_back(idle);
            exp_q.push_back(idle);
            op = ir[15:12]; rs = ir[11:9]; rt = ir[8:6]; rd = ir[5:3]; fn = ir[2:0];
            a  = rf[rs]; b = rf[rt];
            se = {{10{ir[5]}}, ir[5:0]};
            ea = a + se;
            case (op)
                4'd0: begin
                    case (fn)
                        3'd0: r = a + b;
                        3'd1: r = a - b;
                        3'd2: r = a & b;
                        3'd3: r = a | b;
                        3'd4: r = a ^ b;
                        3'd5: r = ($signed(a) < $signed(b)) ? 16'd1 : 16'd0;
                        3'd6: r = a * 2;
                        default: r = a / 2;
                    endcase
                    exp_q.push_back(idle);
                    if (rd != 0) rf[rd] = r;
                end
                4'd1: begin
                    exp_q.push_back(idle);
                    if (rt != 0) rf[rt] = ea;
                end
                4'd2: begin
                    exp_q.push_back(mk(1, 1, 0, 1, 1, ea, 16'h0));
                    exp_q.push_back(idle);
                    if (rt != 0) rf[rt] = mm[ea];
                end
                4'd3: begin
                    exp_q.push_back(mk(1, 0, 1, 1, 1, ea, b));
                    mm[ea] = b;
                end
                4'd4: if (a == b) pc = pc + se;
                4'd5: if (a != b) pc = pc + se;
                4'd6: pc = {pc[15:12], ir[11:0]};
                4'd7: begin
                    exp_q.push_back(mk(1, 0, 1, 0, 1, ea, b));
                    mm[ea][7:0] = b[7:0];
                end
                4'd8: halted = 1;
                default: ;
            endcase
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
    endtask

    task automatic add_pin(input int cyc, input bus_t b);
        pin_t p;
        p.cyc = cyc;
        p.b   = b;
        pins.push_back(p);
    endtask

    // Reset for two cycles, release, then compare every cycle against the model
    task automatic run(input int k, input string tag);
        bus_t act;
        build(k);
        reset = 1'b0;
        @(negedge clock);
        chk({tag, " reset bus"}, 64'(dut_bus()), 64'(mk(0, 0, 0, 0, 0, 16'h0, 16'h0)));
        @(posedge clock);
        @(posedge clock);
        #1 reset = 1'b1;
        for (int i = 0; i < k; i++) begin
            @(negedge clock);
            act = dut_bus();
            chk($sformatf("%s cyc%0d bus", tag, i), 64'(act), 64'(exp_q[i]));
            foreach (pins[j]) begin
                if (pins[j].cyc == i)
                    chk($sformatf("%s pin cyc%0d", tag, i), 64'(act), 64'(pins[j].b));
            end
            if (chip_en && wre) begin
                if (lb_mask) mem[addr[15:0]][7:0]  = data[7:0];
                if (hb_mask) mem[addr[15:0]][15:8] = data[15:8];
            end
        end
        pins.delete();
    endtask

    initial begin
        logic [15:0] w;

        // ADDI r1,r0,5 ; SW r1,20(r0)
        clear_mem();
        mem[0] = 16'h1045; mem[1] = 16'h3054; mem[2] = 16'h8000;
        add_pin(0, mk(1, 1, 0, 1, 1, 16'h0000, 16'h0));
        add_pin(7, mk(1, 0, 1, 1, 1, 16'h0014, 16'h0005));
        run(14, "addi_sw");
        chk("addi_sw mem14", 64'(mem[16'h14]), 64'h0005);

        // LW / ADDI / ADD / SW
        clear_mem();
        mem[16'h14] = 16'h0007;
        mem[0] = 16'h2094; mem[1] = 16'h1043; mem[2] = 16'h0298;
        mem[3] = 16'h30D5; mem[4] = 16'h8000;
        add_pin(3, mk(1, 1, 0, 1, 1, 16'h0014, 16'h0));
        run(24, "load_alu");
        chk("load_alu mem15", 64'(mem[16'h15]), 64'h000A);

        // Branches and jump
        clear_mem();
        for (int i = 0; i < 4; i++) mem[i] = 16'h9000;
        mem[4] = 16'h4002; mem[7] = 16'h5002; mem[8] = 16'h6020; mem[16'h20] = 16'h8000;
        add_pin(15, mk(1, 1, 0, 1, 1, 16'h0007, 16'h0));
        add_pin(18, mk(1, 1, 0, 1, 1, 16'h0008, 16'h0));
        add_pin(21, mk(1, 1, 0, 1, 1, 16'h0020, 16'h0));
        run(26, "branch");

        // Byte store keeps the high byte
        clear_mem();
        mem[16'h10] = 16'h00AB; mem[3] = 16'h5500;
        mem[0] = 16'h2050; mem[1] = 16'h7043; mem[2] = 16'h8000;
        add_pin(8, mk(1, 0, 1, 0, 1, 16'h0003, 16'h00AB));
        run(14, "sb");
        chk("sb mem3", 64'(mem[3]), 64'h55AB);

        // R-type functions with r1=-3, r2=5, results stored to 25..31
        clear_mem();
        mem[0] = 16'h107D; mem[1] = 16'h1085;
        for (int f = 1; f < 8; f++) begin
            w = {4'h0, 3'd1, 3'd2, 3'd3, 3'(f)};
            mem[2*f] = w;
            w = {4'h3, 3'd0, 3'd3, 6'(24 + f)};
            mem[2*f+1] = w;
        end
        mem[16] = 16'h8000;
        run(70, "rtype");
        chk("rtype sub",  64'(mem[25]), 64'hFFF8);
        chk("rtype and",  64'(mem[26]), 64'h0005);
        chk("rtype xor",  64'(mem[28]), 64'hFFF8);
        chk("rtype slt",  64'(mem[29]), 64'h0001);
        chk("rtype sll",  64'(mem[30]), 64'hFFFA);
        chk("rtype srl",  64'(mem[31]), 64'h7FFE);

        // HALT keeps the bus idle
        clear_mem();
        mem[0] = 16'h8000;
        add_pin(22, mk(0, 0, 0, 0, 0, 16'h0000, 16'h0));
        run(24, "halt");

        // Reset during LW MEMRD aborts at once and restarts at address 0
        clear_mem();
        mem[16'h14] = 16'h0007;
        mem[0] = 16'h2094; mem[1] = 16'h3095; mem[2] = 16'h8000;
        add_pin(3, mk(1, 1, 0, 1, 1, 16'h0014, 16'h0));
        run(4, "lw_abort");
        #1 reset = 1'b0;
        #1 chk("abort immediate", 64'(dut_bus()), 64'(mk(0, 0, 0, 0, 0, 16'h0, 16'h0)));
        add_pin(0, mk(1, 1, 0, 1, 1, 16'h0000, 16'h0));
        add_pin(8, mk(1, 0, 1, 1, 1, 16'h0015, 16'h0007));
        run(14, "restart");
        chk("restart mem15", 64'(mem[16'h15]), 64'h0007);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mips16_sram_core.md
Name: mips16_sram_core

Overview:
- Small multicycle 16-bit MIPS-style processor that fetches instructions and loads/stores data through one external asynchronous SRAM port.
- The SRAM is 256K x 16, with an 18-bit address, a bidirectional 16-bit data bus, and active-high strobes.
- Sits at the top of the CPU subsystem. A behavioural Ram model is attached in simulation.
- Instructions and data share the word-addressed memory (von Neumann).

Parameters:
- ADDR_W, 18, SRAM address width.
- DATA_W, 16, data and instruction width.
- RESET_PC, 16'h0000, PC value after reset.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low.
- addr  out  18  SRAM word address = {2'b00, 16-bit address}.
- data  inout  16  SRAM data; driven only while wre=1, otherwise high-Z.
- wre  out  1  write enable, active-high.
- oute  out  1  output enable (SRAM drives data), active-high.
- hb_mask  out  1  high-byte lane enable, data[15:8], active-high.
- lb_mask  out  1  low-byte lane enable, data[7:0], active-high.
- chip_en  out  1  SRAM chip enable, active-high.

Behaviour:
- Reset (reset=0, asynchronous):
  - PC=RESET_PC, IR=0, r0..r7=0, state=FETCH.
  - addr=0, wre=0, oute=0, hb_mask=0, lb_mask=0, chip_en=0, data=Z.
- The first FETCH occurs in the first clock cycle after reset deasserts.
- Register file: 8 x 16 bits. r0 reads 0; writes to r0 are discarded.
- Instruction formats:
  - R-type: op[15:12], rs[11:9], rt[8:6], rd[5:3], funct[2:0].
  - I-type: op, rs, rt, imm6[5:0], sign-extended to 16 bits.
  - J-type: op, target[11:0].
- Opcodes:
  - 0 R-type, by funct: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT (signed; rd=1/0), 6 SLL rs by 1, 7 SRL rs by 1 (logical). Result goes to rd.
  - 1 ADDI: rt=rs+sext(imm).
  - 2 LW: rt=M[rs+sext(imm)].
  - 3 SW: M[rs+sext(imm)]=rt, both lanes.
  - 4 BEQ: if rs==rt, PC=PC+sext(imm), using the already-incremented PC.
  - 5 BNE: same as BEQ, taken when rs!=rt.
  - 6 J: PC={PC[15:12], target}.
  - 7 SB: low-byte store of rt[7:0]; lb_mask=1, hb_mask=0.
  - 8 HALT.
  - 9-15: NOP.
- Arithmetic is 16-bit modulo; carry and overflow are ignored.
- Effective address = 16-bit sum, wrapping at 0xFFFF; it is zero-extended to addr.
- FSM states: FETCH, DECODE, EXEC, MEMRD, MEMWR, WB, HALT.
  - FETCH: addr=PC, chip_en=1, oute=1, hb_mask=lb_mask=1. At the clock edge, IR<=data and PC<=PC+1 (wraps). Next state DECODE.
  - DECODE: read rs/rt into A/B latches. All strobes are 0.
  - EXEC: ALU computes the result or EA; branches and J update PC here.
  - EXEC next state: MEMRD for LW; MEMWR for SW/SB; WB for R-type/ADDI; FETCH for branch/J/NOP; HALT for op 8.
  - MEMRD: addr=EA, chip_en=1, oute=1, both masks=1. Data is sampled into MDR at the edge. Next state WB.
  - MEMWR: addr=EA, chip_en=1, wre=1, oute=0. Core drives data=B, masks per opcode. Next state FETCH.
  - WB: write the result or MDR to the register file. Next state FETCH.
  - HALT: all strobes 0, data=Z. Stays in HALT until reset.
- Instruction latencies: R-type/ADDI 4 cycles, LW 5, SW/SB 4, branch/J/NOP 3.
- wre and oute are never 1 simultaneously.
- The core never drives data while oute=1.
- Strobes are 0 in DECODE, EXEC and WB.
- Reset asserted mid-instruction aborts immediately; the core restarts at FETCH with PC=0.
- The SRAM model's read is combinational (asynchronous); data is valid within the same cycle.

Test Plan:
- Reset check:
  - reset=0 for 2 cycles -> addr=0, wre=oute=chip_en=hb_mask=lb_mask=0, data=Z.
  - Release -> next cycle addr=0, chip_en=1, oute=1, hb_mask=lb_mask=1.
- ADDI then SW: M[0]=0x1045 (ADDI r1,r0,5), M[1]=0x3054 (SW r1,20(r0)).
  - The write cycle shows addr=0x00014, data=0x0005, wre=1, both masks=1.
  - This occurs 8 cycles after reset release.
- Load/ALU: pre-load M[0x14]=0x0007, then LW r2,20(r0), ADDI r1,r0,3, ADD r3,r1,r2 (0x0298), SW r3,21(r0).
  - Required: M[0x15]=0x000A.
- Branch:
  - BEQ r0,r0,+2 at PC=4 -> next fetch addr=7.
  - BNE r0,r0,+2 -> next fetch addr=PC+1.
  - J 0x020 -> fetch addr 0x020.
- Byte store: r1=0x00AB, SB r1,3(r0) -> write cycle lb_mask=1, hb_mask=0, addr=3. SRAM high byte is unchanged.
- HALT and mid-instruction reset:
  - 0x8000 -> chip_en stays 0 for 20 cycles.
  - Asserting reset during an LW MEMRD cycle -> outputs return to reset values immediately.
  - After release, fetch restarts at addr 0.
